// File: rtl/fwd_src_pipe.sv
//==============================================================================
// Module      : fwd_src_pipe
// Description : Producer side of the forwarding interface for a 5-stage RV32I
//               core. Carries register tags from Decode through Execute,
//               Memory and Writeback, and produces the load-use / taken-branch
//               stall and flush controls.
//               Optional macro FWD_SRC_PERF_EN adds saturating stall and flush
//               event counters (stall_cnt_o / flush_cnt_o).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_src_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic                  LoadD,
    input  logic                  PCSrcE,
    input  logic                  stall_i,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic                  RegWriteM,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  RegWriteW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE
`ifdef FWD_SRC_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

    localparam logic [REG_ADDR_W-1:0] c_X0 = '0;

    // Counter width must be at least one bit even when counters are compiled out
    generate
        if (CNT_W < 1) begin : g_cntWidthBad
            $error("fwd_src_pipe: CNT_W must be at least 1");
        end
    endgenerate

    // Pipeline state
    logic [REG_ADDR_W-1:0] r_rs1E;
    logic [REG_ADDR_W-1:0] r_rs2E;
    logic [REG_ADDR_W-1:0] r_rdE;
    logic                  r_regWriteE;
    logic                  r_loadE;
    logic [REG_ADDR_W-1:0] r_rdM;
    logic                  r_regWriteM;
    logic [REG_ADDR_W-1:0] r_rdW;
    logic                  r_regWriteW;

    logic w_ldUse;
    logic w_bubbleE;

    // Load in Execute whose (non-x0) destination is read by the Decode instruction
    assign w_ldUse = r_loadE & (r_rdE != c_X0) &
                     ((r_rdE == Rs1D) | (r_rdE == Rs2D));

    // A taken branch and a load-use both insert a bubble into Execute
    assign w_bubbleE = PCSrcE | w_ldUse;

    // Tag pipeline: freeze on stall_i, otherwise advance with optional E bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs1E      <= '0;
            r_rs2E      <= '0;
            r_rdE       <= '0;
            r_regWriteE <= 1'b0;
            r_loadE     <= 1'b0;
            r_rdM       <= '0;
            r_regWriteM <= 1'b0;
            r_rdW       <= '0;
            r_regWriteW <= 1'b0;
        end else if (!stall_i) begin
            r_rdW       <= r_rdM;
            r_regWriteW <= r_regWriteM;
            r_rdM       <= r_rdE;
            r_regWriteM <= r_regWriteE;
            if (w_bubbleE) begin
                r_rs1E      <= '0;
                r_rs2E      <= '0;
                r_rdE       <= '0;
                r_regWriteE <= 1'b0;
                r_loadE     <= 1'b0;
            end else begin
                r_rs1E      <= Rs1D;
                r_rs2E      <= Rs2D;
                r_rdE       <= RdD;
                // x0 is never advertised as a writable destination downstream
                r_regWriteE <= RegWriteD & (RdD != c_X0);
                r_loadE     <= LoadD;
            end
        end
    end

    assign Rs1E      = r_rs1E;
    assign Rs2E      = r_rs2E;
    assign RdM       = r_rdM;
    assign RegWriteM = r_regWriteM;
    assign RdW       = r_rdW;
    assign RegWriteW = r_regWriteW;

    // Hazard controls; a branch overrides the load-use stall since Decode is flushed
    assign StallF = stall_i | (w_ldUse & ~PCSrcE);
    assign StallD = stall_i | (w_ldUse & ~PCSrcE);
    assign FlushD = PCSrcE & ~stall_i;
    assign FlushE = (PCSrcE | w_ldUse) & ~stall_i;

`ifdef FWD_SRC_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Saturating event counters for load-use stalls and taken-branch flushes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_ldUse & ~PCSrcE & ~stall_i & ~(&r_stallCnt)) begin
                r_stallCnt <= r_stallCnt + c_CNT_ONE;
            end
            if (PCSrcE & ~stall_i & ~(&r_flushCnt)) begin
                r_flushCnt <= r_flushCnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = r_stallCnt;
    assign flush_cnt_o = r_flushCnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_src_pipe.sv
//==============================================================================
// Module      : tb_fwd_src_pipe
// Description : Self-checking bench for fwd_src_pipe. Directed scenarios plus a
//               randomized run compared against an instruction-record model of
//               the E/M/W pipeline. Counter checks compile in with
//               FWD_SRC_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fwd_src_pipe;

    localparam int W = 5;
    localparam int CW = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] Rs1D, Rs2D, RdD;
    logic         RegWriteD, LoadD, PCSrcE, stall_i;
    logic [W-1:0] Rs1E, Rs2E, RdM, RdW;
    logic         RegWriteM, RegWriteW;
    logic         StallF, StallD, FlushD, FlushE;
`ifdef FWD_SRC_PERF_EN
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;
`endif

    fwd_src_pipe #(.REG_ADDR_W(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .LoadD      (LoadD),
        .PCSrcE     (PCSrcE),
        .stall_i    (stall_i),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE)
`ifdef FWD_SRC_PERF_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: an in-flight instruction record per stage (index 0=E,1=M,2=W)
    typedef struct packed {
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic [W-1:0] rd;
        logic         we;
        logic         ld;
    } instr_t;

    instr_t mPipe [3];
    longint mStallCnt = 0;
    longint mFlushCnt = 0;

    function automatic bit modelLdUse();
        return mPipe[0].ld && (mPipe[0].rd != 0) &&
               (mPipe[0].rd == Rs1D || mPipe[0].rd == Rs2D);
    endfunction

    function automatic bit expStall();
        return stall_i || (modelLdUse() && !PCSrcE);
    endfunction

    function automatic bit expFlushD();
        return PCSrcE && !stall_i;
    endfunction

    function automatic bit expFlushE();
        return (PCSrcE || modelLdUse()) && !stall_i;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        instr_t nxt;
        bit     lu;
        @(posedge clk);
        lu = modelLdUse();
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mPipe[i] = '0;
            mStallCnt = 0;
            mFlushCnt = 0;
        end else if (!stall_i) begin
            if (lu && !PCSrcE) mStallCnt = (mStallCnt == (2**CW - 1)) ? mStallCnt : mStallCnt + 1;
            if (PCSrcE)        mFlushCnt = (mFlushCnt == (2**CW - 1)) ? mFlushCnt : mFlushCnt + 1;
            if (PCSrcE || lu) nxt = '0;
            else nxt = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, we: RegWriteD && (RdD != 0), ld: LoadD};
            mPipe[2] = mPipe[1];
            mPipe[1] = mPipe[0];
            mPipe[0] = nxt;
        end
        #1;
    endtask

    task automatic driveD(input int rs1, input int rs2, input int rd, input bit we, input bit ld);
        Rs1D      = W'(rs1);
        Rs2D      = W'(rs2);
        RdD       = W'(rd);
        RegWriteD = we;
        LoadD     = ld;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PCSrcE = 1'b0; stall_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            driveD($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   1'($urandom), 1'($urandom));
            tick();
        end
        #1;
        nChecks++;
        if ({Rs1E, Rs2E, RdM, RegWriteM, RdW, RegWriteW} !== '0) begin
            nErrors++;
            $display("FAIL reset_regs: got Rs1E=%0d Rs2E=%0d RdM=%0d WeM=%0b RdW=%0d WeW=%0b, want all 0",
                     Rs1E, Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        end
        nChecks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
            nErrors++;
            $display("FAIL reset_ctrl: got StallF/StallD/FlushD/FlushE=%b, want 0000",
                     {StallF, StallD, FlushD, FlushE});
        end
        rst_n = 1'b1;
        driveD(3, 0, 7, 1, 0);
        tick();
        nChecks++;
        if (Rs1E !== 5'd3) begin
            nErrors++; $display("FAIL lat_rs1e: got %0d want 3", Rs1E);
        end
        driveD(0, 0, 0, 0, 0);
        tick();
        nChecks++;
        if (RdM !== 5'd7 || RegWriteM !== 1'b1) begin
            nErrors++; $display("FAIL lat_rdm: got RdM=%0d WeM=%0b want 7/1", RdM, RegWriteM);
        end
        tick();
        nChecks++;
        if (RdW !== 5'd7 || RegWriteW !== 1'b1) begin
            nErrors++; $display("FAIL lat_rdw: got RdW=%0d WeW=%0b want 7/1", RdW, RegWriteW);
        end
    endtask

    task automatic test_x0_filter();
        driveD(1, 2, 0, 1, 0);
        tick();
        driveD(0, 0, 9, 1, 0);
        tick();
        nChecks++;
        if (RegWriteM !== 1'b0 || RdM !== 5'd0) begin
            nErrors++; $display("FAIL x0_wem: got RdM=%0d WeM=%0b want 0/0", RdM, RegWriteM);
        end
        driveD(0, 0, 0, 0, 0);
        tick();
        nChecks++;
        if (RegWriteW !== 1'b0 || RegWriteM !== 1'b1 || RdM !== 5'd9) begin
            nErrors++;
            $display("FAIL x0_wew: got WeW=%0b RdM=%0d WeM=%0b want 0/9/1", RegWriteW, RdM, RegWriteM);
        end
    endtask

    task automatic test_load_use();
        driveD(0, 0, 5, 1, 1);          // lw x5
        tick();
        driveD(5, 0, 8, 1, 0);          // add x8, x5, x0
        #1;
        nChecks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
            nErrors++; $display("FAIL lduse_ctrl: got %b want 1101", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        nChecks++;
        if (Rs1E !== 5'd0 || RdM !== 5'd5 || StallF !== 1'b0) begin
            nErrors++;
            $display("FAIL lduse_bubble: got Rs1E=%0d RdM=%0d StallF=%0b want 0/5/0", Rs1E, RdM, StallF);
        end
        tick();
        nChecks++;
        if (Rs1E !== 5'd5 || RdM !== 5'd0 || RdW !== 5'd5) begin
            nErrors++;
            $display("FAIL lduse_resume: got Rs1E=%0d RdM=%0d RdW=%0d want 5/0/5", Rs1E, RdM, RdW);
        end
        driveD(0, 0, 5, 1, 1);
        tick();
        driveD(6, 7, 3, 1, 0);          // unrelated sources
        #1;
        nChecks++;
        if (StallF !== 1'b0 || FlushE !== 1'b0) begin
            nErrors++; $display("FAIL lduse_none: got StallF=%0b FlushE=%0b want 0/0", StallF, FlushE);
        end
        tick();
        nChecks++;
        if (Rs1E !== 5'd6 || Rs2E !== 5'd7) begin
            nErrors++; $display("FAIL lduse_none_adv: got Rs1E=%0d Rs2E=%0d want 6/7", Rs1E, Rs2E);
        end
    endtask

    task automatic test_branch();
        driveD(1, 2, 3, 1, 0);
        tick();
        PCSrcE = 1'b1;
        driveD(4, 4, 4, 1, 0);
        #1;
        nChecks++;
        if ({StallF, FlushD, FlushE} !== 3'b011) begin
            nErrors++; $display("FAIL br_ctrl: got StallF/FlushD/FlushE=%b want 011", {StallF, FlushD, FlushE});
        end
        tick();
        PCSrcE = 1'b0;
        nChecks++;
        if (Rs1E !== 5'd0 || RdM !== 5'd3) begin
            nErrors++; $display("FAIL br_bubble: got Rs1E=%0d RdM=%0d want 0/3", Rs1E, RdM);
        end
        driveD(0, 0, 5, 1, 1);
        tick();
        driveD(5, 0, 1, 1, 0);
        PCSrcE = 1'b1;
        #1;
        nChecks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            nErrors++; $display("FAIL br_lduse: got %b want 0011", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        PCSrcE = 1'b0;
        nChecks++;
        if (Rs1E !== 5'd0 || RdM !== 5'd5) begin
            nErrors++; $display("FAIL br_lduse_adv: got Rs1E=%0d RdM=%0d want 0/5", Rs1E, RdM);
        end
    endtask

    task automatic test_freeze();
        driveD(1, 2, 3, 1, 0);
        tick();
        stall_i = 1'b1;
        PCSrcE  = 1'b1;
        driveD(9, 9, 9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            nChecks++;
            if ({StallF, StallD, FlushD, FlushE} !== 4'b1100) begin
                nErrors++; $display("FAIL frz_ctrl%0d: got %b want 1100", i, {StallF, StallD, FlushD, FlushE});
            end
            tick();
            nChecks++;
            if (Rs1E !== 5'd1 || Rs2E !== 5'd2) begin
                nErrors++; $display("FAIL frz_hold%0d: got Rs1E=%0d Rs2E=%0d want 1/2", i, Rs1E, Rs2E);
            end
        end
        stall_i = 1'b0;
        #1;
        nChecks++;
        if ({StallF, FlushD, FlushE} !== 3'b011) begin
            nErrors++; $display("FAIL frz_release: got %b want 011", {StallF, FlushD, FlushE});
        end
        tick();
        PCSrcE = 1'b0;
        nChecks++;
        if (Rs1E !== 5'd0 || RdM !== 5'd3) begin
            nErrors++; $display("FAIL frz_flush: got Rs1E=%0d RdM=%0d want 0/3", Rs1E, RdM);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 99) >= 2);
            stall_i = ($urandom_range(0, 99) < 15);
            PCSrcE  = ($urandom_range(0, 99) < 15);
            driveD($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 35));
            #1;
            nChecks++;
            if (StallF !== expStall() || StallD !== expStall() ||
                FlushD !== expFlushD() || FlushE !== expFlushE()) begin
                nErrors++;
                $display("FAIL rnd_ctrl@%0d: got %b want %b", n, {StallF, StallD, FlushD, FlushE},
                         {expStall(), expStall(), expFlushD(), expFlushE()});
            end
            tick();
            nChecks++;
            if (Rs1E !== mPipe[0].rs1 || Rs2E !== mPipe[0].rs2 ||
                RdM !== mPipe[1].rd || RegWriteM !== mPipe[1].we ||
                RdW !== mPipe[2].rd || RegWriteW !== mPipe[2].we) begin
                nErrors++;
                $display("FAIL rnd_regs@%0d: got %0d/%0d/%0d:%0b/%0d:%0b want %0d/%0d/%0d:%0b/%0d:%0b", n,
                         Rs1E, Rs2E, RdM, RegWriteM, RdW, RegWriteW,
                         mPipe[0].rs1, mPipe[0].rs2, mPipe[1].rd, mPipe[1].we, mPipe[2].rd, mPipe[2].we);
            end
`ifdef FWD_SRC_PERF_EN
            nChecks++;
            if (stall_cnt_o !== CW'(mStallCnt) || flush_cnt_o !== CW'(mFlushCnt)) begin
                nErrors++;
                $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", n,
                         stall_cnt_o, flush_cnt_o, mStallCnt, mFlushCnt);
            end
`endif
        end
        rst_n = 1'b1; stall_i = 1'b0; PCSrcE = 1'b0;
    endtask

`ifdef FWD_SRC_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0; stall_i = 1'b0; PCSrcE = 1'b0;
        driveD(0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            driveD(0, 0, 5, 1, 1);
            tick();
            driveD(5, 5, 2, 1, 0);
            tick();                 // load-use stall edge
            tick();                 // dependent instruction enters E
        end
        driveD(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            PCSrcE = 1'b1;
            tick();
            PCSrcE = 1'b0;
            tick();
        end
        nChecks++;
        if (stall_cnt_o !== 32'd4 || flush_cnt_o !== 32'd2) begin
            nErrors++; $display("FAIL perf_cnt: got %0d/%0d want 4/2", stall_cnt_o, flush_cnt_o);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; PCSrcE = 1'b0;
        driveD(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) mPipe[i] = '0;
        test_reset();
        test_x0_filter();
        test_load_use();
        test_branch();
        test_freeze();
        test_random();
`ifdef FWD_SRC_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
